// File: rtl/heli_motion_ctrl_pkg.sv
// Shared definitions for the helicopter motion controller: state encodings,
// parameter defaults and a saturating score helper.
package heli_motion_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOME   = 3'd0,
        ST_READY  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_MOVE   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_CRASH  = 3'd5
    } heli_state_e;

    localparam int N_DEF        = 6;
    localparam int HOME_POS_DEF = 64;
    localparam int VMAX_DEF     = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/heli_motion_ctrl_step_gen.sv
// Step engine: holds the remaining step count for a frame and drives the
// registered enable/up/down pulses to the offset counter (homing and flight).
module heli_step_gen
    import heli_motion_ctrl_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [SW-1:0] load_steps_i,
    input  logic          in_move_i,
    input  logic          dir_up_i,
    input  logic          abort_i,
    input  logic          home_up_i,
    input  logic          home_dn_i,
    input  logic [N:0]    pos_i,
    output logic          heli_en_o,
    output logic          heli_up_o,
    output logic          heli_down_o,
    output logic          more_o,
    output logic          at_limit_o
);

    localparam logic [N:0] POS_MAX = {(N+1){1'b1}};
    localparam logic [N:0] POS_MIN = {(N+1){1'b0}};

    logic [SW-1:0] steps_q;
    logic [SW-1:0] steps_d;
    logic          up_d;
    logic          dn_d;

    // The counter must never wrap, so the edge in the travel direction stops motion.
    assign at_limit_o = dir_up_i ? (pos_i == POS_MAX) : (pos_i == POS_MIN);
    assign more_o     = (steps_q != {SW{1'b0}});

    // Next step count and pulse request; abort beats everything, including the MOVE pulse.
    always_comb begin
        steps_d = steps_q;
        up_d    = home_up_i;
        dn_d    = home_dn_i;
        if (abort_i) begin
            steps_d = {SW{1'b0}};
            up_d    = 1'b0;
            dn_d    = 1'b0;
        end else if (load_i) begin
            steps_d = load_steps_i;
        end else if (in_move_i) begin
            if (at_limit_o) begin
                steps_d = {SW{1'b0}};
            end else begin
                steps_d = steps_q - SW'(1);
                up_d    = dir_up_i;
                dn_d    = !dir_up_i;
            end
        end else begin
            steps_d = steps_q;
        end
    end

    // Step counter and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steps_q     <= {SW{1'b0}};
            heli_en_o   <= 1'b0;
            heli_up_o   <= 1'b0;
            heli_down_o <= 1'b0;
        end else begin
            steps_q     <= steps_d;
            heli_en_o   <= up_d | dn_d;
            heli_up_o   <= up_d;
            heli_down_o <= dn_d;
        end
    end

endmodule

// File: rtl/heli_motion_ctrl.sv
// Helicopter motion controller: game FSM, signed velocity and score; stepping
// pulses to the external offset counter come from heli_step_gen.
module heli_motion_ctrl
    import heli_motion_ctrl_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int HOME_POS = HOME_POS_DEF,
    parameter int VMAX     = VMAX_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        fly,
    input  logic        tick,
    input  logic        collide,
    input  logic [N:0]  pos,
    output logic        heli_en,
    output logic        heli_up,
    output logic        heli_down,
    output logic [2:0]  state,
    output logic [15:0] score
);

    localparam int SW = $clog2(VMAX + 1);
    localparam int VW = SW + 1;
    localparam logic [N:0]           HOME_V  = (N+1)'(HOME_POS);
    localparam logic signed [VW-1:0] VEL_MAX = VW'(VMAX);
    localparam logic signed [VW-1:0] VEL_MIN = -VEL_MAX;
    localparam logic signed [VW-1:0] VEL_ONE = VW'(1);

    heli_state_e           state_q;
    logic signed [VW-1:0]  vel_q;
    logic signed [VW-1:0]  vel_d;
    logic [SW-1:0]         steps_d;
    logic [15:0]           score_q;
    logic                  home_idle_q;

    logic load_s;
    logic abort_s;
    logic home_up_s;
    logic home_dn_s;
    logic in_move_s;
    logic dir_up_s;
    logic more_s;
    logic at_limit_s;

    // Frame velocity update (thrust or gravity, saturating) and derived step count.
    always_comb begin
        vel_d = vel_q;
        if (fly) begin
            if (vel_q >= VEL_MAX) begin
                vel_d = vel_q;
            end else begin
                vel_d = vel_q + VEL_ONE;
            end
        end else begin
            if (vel_q <= VEL_MIN) begin
                vel_d = vel_q;
            end else begin
                vel_d = vel_q - VEL_ONE;
            end
        end
        steps_d = vel_d[VW-1] ? SW'(-vel_d) : SW'(vel_d);
    end

    // Requests to the step engine decoded from the current state.
    always_comb begin
        load_s    = (state_q == ST_WAIT) && tick && !collide && (steps_d != {SW{1'b0}});
        abort_s   = collide && ((state_q == ST_WAIT) || (state_q == ST_MOVE) ||
                                (state_q == ST_SETTLE));
        home_up_s = (state_q == ST_HOME) && !home_idle_q && (pos < HOME_V);
        home_dn_s = (state_q == ST_HOME) && !home_idle_q && (pos > HOME_V);
        in_move_s = (state_q == ST_MOVE);
        dir_up_s  = !vel_q[VW-1];
    end

    // Game FSM with velocity, score and homing pacing.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q     <= ST_HOME;
            vel_q       <= '0;
            score_q     <= 16'd0;
            home_idle_q <= 1'b0;
        end else begin
            case (state_q)
                ST_HOME: begin
                    if (home_idle_q) begin
                        home_idle_q <= 1'b0;
                    end else if (pos == HOME_V) begin
                        state_q <= ST_READY;
                    end else begin
                        home_idle_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (start) begin
                        state_q <= ST_WAIT;
                        vel_q   <= '0;
                        score_q <= 16'd0;
                    end
                end
                ST_WAIT: begin
                    // Collision wins over a coincident frame tick.
                    if (collide) begin
                        state_q <= ST_CRASH;
                    end else if (tick) begin
                        vel_q   <= vel_d;
                        score_q <= sat_inc16(score_q);
                        if (steps_d != {SW{1'b0}}) begin
                            state_q <= ST_MOVE;
                        end
                    end
                end
                ST_MOVE: begin
                    if (collide || at_limit_s) begin
                        state_q <= ST_CRASH;
                    end else begin
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (collide) begin
                        state_q <= ST_CRASH;
                    end else if (more_s) begin
                        state_q <= ST_MOVE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_CRASH: begin
                    if (start) begin
                        state_q     <= ST_HOME;
                        home_idle_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_HOME;
                end
            endcase
        end
    end

    heli_step_gen #(
        .N  (N),
        .SW (SW)
    ) u_step_gen (
        .clk          (clk),
        .rst          (resetn),
        .load_i       (load_s),
        .load_steps_i (steps_d),
        .in_move_i    (in_move_s),
        .dir_up_i     (dir_up_s),
        .abort_i      (abort_s),
        .home_up_i    (home_up_s),
        .home_dn_i    (home_dn_s),
        .pos_i        (pos),
        .heli_en_o    (heli_en),
        .heli_up_o    (heli_up),
        .heli_down_o  (heli_down),
        .more_o       (more_s),
        .at_limit_o   (at_limit_s)
    );

    assign state = state_q;
    assign score = score_q;

endmodule

// File: tb/tb_heli_motion_ctrl.sv
// Directed bench for heli_motion_ctrl with an offset-counter model in the loop
// and a scoreboard checked whenever the DUT settles in READY, WAIT or CRASH.
module tb_heli_motion_ctrl;

    localparam int N = 6;
    localparam logic [2:0] S_HOME = 3'd0, S_READY = 3'd1, S_WAIT = 3'd2,
                           S_MOVE = 3'd3, S_SETTLE = 3'd4, S_CRASH = 3'd5;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0, fly = 1'b0, tick = 1'b0, collide = 1'b0;
    logic [N:0]  pos;
    logic        heli_en, heli_up, heli_down;
    logic [2:0]  state;
    logic [15:0] score;
    logic        cnt_load = 1'b1;
    logic [N:0]  cnt_val = 7'd0;

    int checks = 0;
    int errors = 0;
    int excl_viol = 0;

    typedef struct {
        logic [2:0]  st;
        logic [N:0]  p;
        logic [15:0] sc;
        bit          chk_sc;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    heli_motion_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .fly       (fly),
        .tick      (tick),
        .collide   (collide),
        .pos       (pos),
        .heli_en   (heli_en),
        .heli_up   (heli_up),
        .heli_down (heli_down),
        .state     (state),
        .score     (score)
    );

    // Offset counter: bench can preload it, otherwise it follows the step pulses.
    always @(posedge clk) begin
        if (cnt_load)                  pos <= cnt_val;
        else if (heli_en && heli_up)   pos <= pos + 7'd1;
        else if (heli_en && heli_down) pos <= pos - 7'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [N:0] p, input logic [15:0] sc,
                        input bit chk_sc, input string name);
        exp_t e;
        e.st = st; e.p = p; e.sc = sc; e.chk_sc = chk_sc; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int k = 0;
        while (state !== st && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_reached"}, {29'd0, state}, {29'd0, st});
    endtask

    task automatic do_tick(input logic f);
        fly = f; tick = 1'b1;
        @(negedge clk);
        fly = 1'b0; tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: pops an expectation on every entry into a settled state.
    initial begin
        logic [2:0] prev;
        exp_t e;
        prev = S_HOME;
        forever begin
            @(negedge clk);
            if (heli_up && heli_down) excl_viol++;
            if ((heli_up || heli_down) && !heli_en) excl_viol++;
            if (state !== prev && (state == S_READY || state == S_WAIT || state == S_CRASH)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_settle: got state %0d, expected no settle", state);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_state"}, {29'd0, state}, {29'd0, e.st});
                    check({e.name, "_pos"}, {25'd0, pos}, {25'd0, e.p});
                    if (e.chk_sc) check({e.name, "_score"}, {16'd0, score}, {16'd0, e.sc});
                end
            end
            prev = state;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses, last, gap_bad, k, quiet;
        int exp_fall[6] = '{63, 61, 58, 54, 50, 46};

        // Reset with the counter held at 0.
        repeat (3) @(negedge clk);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_en", {31'd0, heli_en}, 32'd0);
        check("rst_updown", {30'd0, heli_up, heli_down}, 32'd0);
        check("rst_score", {16'd0, score}, 32'd0);

        // Homing from 0: 64 up pulses two cycles apart.
        push(S_READY, 7'd64, 16'd0, 1'b1, "home0");
        resetn = 1'b0; cnt_load = 1'b0;
        pulses = 0; last = -1; gap_bad = 0; k = 0;
        while (state !== S_READY && k < 400) begin
            @(negedge clk);
            k++;
            if (heli_en && heli_down) gap_bad++;
            if (heli_en && heli_up) begin
                if (last >= 0 && k - last != 2) gap_bad++;
                last = k;
                pulses++;
            end
        end
        check("home0_reached", {29'd0, state}, {29'd0, S_READY});
        check("home0_pulses", pulses, 32'd64);
        check("home0_spacing", gap_bad, 32'd0);

        // Three thrust frames: vel 1,2,3; an extra tick during MOVE is ignored.
        push(S_WAIT, 7'd64, 16'd0, 1'b1, "run1_start");
        pulse_start();
        wait_state(S_WAIT, 5, "run1_start");
        push(S_WAIT, 7'd65, 16'd1, 1'b1, "fly1");
        do_tick(1'b1);
        wait_state(S_WAIT, 50, "fly1");
        push(S_WAIT, 7'd67, 16'd2, 1'b1, "fly2");
        do_tick(1'b1);
        wait_state(S_WAIT, 50, "fly2");
        push(S_WAIT, 7'd70, 16'd3, 1'b1, "fly3");
        do_tick(1'b1);
        do_tick(1'b1);
        wait_state(S_WAIT, 50, "fly3");

        // Plain collision, restart; homing comes back down to 64.
        push(S_CRASH, 7'd70, 16'd3, 1'b1, "collide1");
        collide = 1'b1;
        @(negedge clk);
        collide = 1'b0;
        wait_state(S_CRASH, 5, "collide1");
        push(S_READY, 7'd64, 16'd0, 1'b0, "home70");
        pulse_start();
        wait_state(S_READY, 100, "home70");

        // Six gravity frames from rest: displacement -18 with vel clamped at -4.
        push(S_WAIT, 7'd64, 16'd0, 1'b1, "run2_start");
        pulse_start();
        wait_state(S_WAIT, 5, "run2_start");
        for (int i = 0; i < 6; i++) begin
            push(S_WAIT, exp_fall[i][N:0], 16'(i + 1), 1'b1, "fall");
            do_tick(1'b0);
            wait_state(S_WAIT, 50, "fall");
        end

        // Collide with tick: crash, score and pos frozen, no pulses afterwards.
        push(S_CRASH, 7'd46, 16'd6, 1'b1, "collide_tick");
        collide = 1'b1; tick = 1'b1;
        @(negedge clk);
        collide = 1'b0; tick = 1'b0;
        wait_state(S_CRASH, 5, "collide_tick");
        quiet = 0;
        repeat (10) begin
            @(negedge clk);
            if (heli_en) quiet++;
        end
        check("crash_quiet", quiet, 32'd0);
        check("crash_score_held", {16'd0, score}, 32'd6);
        push(S_READY, 7'd64, 16'd0, 1'b0, "home46");
        pulse_start();
        wait_state(S_READY, 100, "home46");

        // Floor: pos forced to 1 with vel -1, next gravity frame -> one step to 0 then crash.
        push(S_WAIT, 7'd64, 16'd0, 1'b1, "run3_start");
        pulse_start();
        wait_state(S_WAIT, 5, "run3_start");
        push(S_WAIT, 7'd63, 16'd1, 1'b1, "drop1");
        do_tick(1'b0);
        wait_state(S_WAIT, 50, "drop1");
        cnt_val = 7'd1; cnt_load = 1'b1;
        @(negedge clk);
        cnt_load = 1'b0;
        push(S_CRASH, 7'd0, 16'd2, 1'b1, "floor");
        do_tick(1'b0);
        wait_state(S_CRASH, 50, "floor");
        repeat (6) @(negedge clk);
        check("floor_no_wrap", {25'd0, pos}, 32'd0);

        // Reset while a step pulse is on: outputs drop at once, homing resumes after.
        push(S_READY, 7'd64, 16'd0, 1'b0, "home0b");
        pulse_start();
        wait_state(S_READY, 400, "home0b");
        push(S_WAIT, 7'd64, 16'd0, 1'b1, "run4_start");
        pulse_start();
        wait_state(S_WAIT, 5, "run4_start");
        do_tick(1'b1);
        k = 0;
        while (!heli_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("pulse_seen", {31'd0, heli_en}, 32'd1);
        #1 resetn = 1'b1;
        #1;
        check("async_rst_en", {31'd0, heli_en}, 32'd0);
        check("async_rst_up", {31'd0, heli_up}, 32'd0);
        check("async_rst_state", {29'd0, state}, {29'd0, S_HOME});
        check("async_rst_score", {16'd0, score}, 32'd0);
        repeat (2) @(negedge clk);
        push(S_READY, 7'd64, 16'd0, 1'b1, "home_after_rst");
        resetn = 1'b0;
        check("rel_state", {29'd0, state}, {29'd0, S_HOME});
        wait_state(S_READY, 20, "home_after_rst");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("updown_exclusive", excl_viol, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
